dmem_bus_ctrl: RTL

Load/store bus controller between the CPU memory stage and the data-memory block (dmem with its byte-lane converter). It accepts one request at a time over a valid/ready handshake and decodes the address into the DMEM region, the MMIO region or unmapped space. Misaligned, illegal and unmapped accesses are rejected with an error response. Two peripherals live in the MMIO region: an 8-bit keyboard scan-code FIFO and a free-running cycle counter.

---
 rtl/dmem_bus_ctrl.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/dmem_bus_ctrl.sv
// Load/store bus controller: decodes CPU requests into DMEM, MMIO or error responses.
// MMIO hosts an 8-bit keyboard scan-code FIFO and a free-running cycle counter.
module dmem_bus_ctrl #(
  parameter int unsigned KBD_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_memop,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_datain,
  output logic [2:0]  mem_memop,
  output logic        mem_we,
  input  logic [31:0] mem_dataout,
  input  logic        kbd_valid,
  input  logic [7:0]  kbd_code
);

  localparam int unsigned AW = $clog2(KBD_DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {IDLE, D_ISSUE, D_RESP, M_RESP} state_t;

  state_t state, state_nxt;

  logic          rsp_valid_nxt, rsp_err_nxt, mem_we_nxt, mem_load;
  logic [31:0]   rsp_rdata_nxt;

  logic [7:0]    fifo [KBD_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          ovf;
  logic [31:0]   cycles;

  // Address decode and access legality
  logic is_dmem, is_mmio, acc_err, dmem_ok, mmio_ok, accept;
  logic [1:0] off;

  assign is_dmem = (req_addr[31:20] == 12'h001);
  assign is_mmio = (req_addr[31:20] == 12'h002);
  assign off     = req_addr[3:2];
  assign acc_err = ~(is_dmem | is_mmio)
                 | (req_memop inside {3'b011, 3'b110, 3'b111})
                 | (req_we & (req_memop inside {3'b100, 3'b101}))
                 | ((req_memop inside {3'b001, 3'b101}) & req_addr[0])
                 | ((req_memop == 3'b010) & (req_addr[1:0] != 2'b00))
                 | (is_mmio & (req_memop != 3'b010));
  assign dmem_ok = is_dmem & ~acc_err;
  assign mmio_ok = is_mmio & ~acc_err;
  assign accept  = req_valid & (state == IDLE);

  // MMIO side effects, all committed on the accept edge
  logic empty, full, pop, push, ovf_clr, cyc_ld;
  logic [31:0] mmio_rdata;

  assign empty   = (count == '0);
  assign full    = (count == CW'(KBD_DEPTH));
  assign pop     = accept & mmio_ok & ~req_we & (off == 2'd0) & ~empty;
  assign push    = kbd_valid & (~full | pop);
  assign ovf_clr = accept & mmio_ok & req_we & (off == 2'd1) & req_wdata[1];
  assign cyc_ld  = accept & mmio_ok & req_we & (off == 2'd2);

  always_comb begin
    mmio_rdata = '0;
    if (!req_we) begin
      unique case (off)
        2'd0:    mmio_rdata = empty ? 32'd0 : {24'd0, fifo[rd_ptr]};
        2'd1:    mmio_rdata = {30'd0, ovf, ~empty};
        2'd2:    mmio_rdata = cycles;
        default: mmio_rdata = '0;
      endcase
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_nxt     = state;
    rsp_valid_nxt = 1'b0;
    rsp_err_nxt   = 1'b0;
    rsp_rdata_nxt = '0;
    mem_we_nxt    = 1'b0;
    mem_load      = 1'b0;
    unique case (state)
      IDLE: begin
        if (req_valid) begin
          if (dmem_ok) begin
            state_nxt  = D_ISSUE;
            mem_we_nxt = req_we;
            mem_load   = 1'b1;
          end else begin
            state_nxt     = M_RESP;
            rsp_valid_nxt = 1'b1;
            rsp_err_nxt   = acc_err;
            rsp_rdata_nxt = acc_err ? 32'd0 : mmio_rdata;
          end
        end
      end
      D_ISSUE: begin
        state_nxt     = D_RESP;
        rsp_valid_nxt = 1'b1;
        rsp_rdata_nxt = mem_we ? 32'd0 : mem_dataout;
      end
      D_RESP:  state_nxt = IDLE;
      M_RESP:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  // Registered bus outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      req_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_err    <= 1'b0;
      rsp_rdata  <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_datain <= '0;
      mem_memop  <= '0;
    end else begin
      req_ready <= (state_nxt == IDLE);
      rsp_valid <= rsp_valid_nxt;
      rsp_err   <= rsp_err_nxt;
      rsp_rdata <= rsp_rdata_nxt;
      mem_we    <= mem_we_nxt;
      if (mem_load) begin
        mem_addr   <= req_addr;
        mem_datain <= req_wdata;
        mem_memop  <= req_memop;
      end
    end
  end

  // Keyboard FIFO; a push into a full FIFO survives only when a pop frees a slot
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < KBD_DEPTH; i++) fifo[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) begin
        fifo[wr_ptr] <= kbd_code;
        wr_ptr       <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (kbd_valid & full & ~pop) ovf <= 1'b1;
      else if (ovf_clr)            ovf <= 1'b0;
    end
  end

  // Free-running cycle counter; a load replaces that edge's increment
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)       cycles <= '0;
    else if (cyc_ld) cycles <= req_wdata;
    else             cycles <= cycles + 32'd1;
  end

endmodule
